// File: rtl/alu_ctrl_mdu_pkg.sv
// Shared codes for the EX-stage ALU control decoder and the iterative multiply/divide unit.
package alu_ctrl_mdu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLTU = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_NOR  = 4'b1100;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [5:0] FUNC_ADD   = 6'b100000;
  localparam logic [5:0] FUNC_SUB   = 6'b100010;
  localparam logic [5:0] FUNC_AND   = 6'b100100;
  localparam logic [5:0] FUNC_OR    = 6'b100101;
  localparam logic [5:0] FUNC_XOR   = 6'b100110;
  localparam logic [5:0] FUNC_NOR   = 6'b100111;
  localparam logic [5:0] FUNC_SLT   = 6'b101010;
  localparam logic [5:0] FUNC_SLTU  = 6'b101011;
  localparam logic [5:0] FUNC_MULT  = 6'b011000;
  localparam logic [5:0] FUNC_MULTU = 6'b011001;
  localparam logic [5:0] FUNC_DIV   = 6'b011010;
  localparam logic [5:0] FUNC_DIVU  = 6'b011011;
  localparam logic [5:0] FUNC_MFHI  = 6'b010000;
  localparam logic [5:0] FUNC_MTHI  = 6'b010001;
  localparam logic [5:0] FUNC_MFLO  = 6'b010010;
  localparam logic [5:0] FUNC_MTLO  = 6'b010011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } mdu_state_e;

  typedef struct packed {
    logic [3:0] ctrl;
    logic       illegal;
    logic       mdu_op;   // MULT/MULTU/DIV/DIVU
    logic       mf;       // MFHI/MFLO
    logic       mt;       // MTHI/MTLO
  } dec_t;

  function automatic dec_t decode(input logic [1:0] aluop, input logic [5:0] f);
    dec_t d;
    d      = '0;
    d.ctrl = ALU_ADD;
    case (aluop)
      ALUOP_SUB: d.ctrl = ALU_SUB;
      ALUOP_OR:  d.ctrl = ALU_OR;
      ALUOP_RTYPE: begin
        case (f)
          FUNC_ADD:  d.ctrl = ALU_ADD;
          FUNC_SUB:  d.ctrl = ALU_SUB;
          FUNC_AND:  d.ctrl = ALU_AND;
          FUNC_OR:   d.ctrl = ALU_OR;
          FUNC_XOR:  d.ctrl = ALU_XOR;
          FUNC_NOR:  d.ctrl = ALU_NOR;
          FUNC_SLT:  d.ctrl = ALU_SLT;
          FUNC_SLTU: d.ctrl = ALU_SLTU;
          FUNC_MULT, FUNC_MULTU, FUNC_DIV, FUNC_DIVU: d.mdu_op = 1'b1;
          FUNC_MFHI, FUNC_MFLO: d.mf = 1'b1;
          FUNC_MTHI, FUNC_MTLO: d.mt = 1'b1;
          default: d.illegal = 1'b1;
        endcase
      end
      default: d.ctrl = ALU_ADD;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_ctrl_mdu_core.sv
// Iterative MDU datapath: shift-add multiply / restoring divide on magnitudes, sign fix on the way out.
module alu_ctrl_mdu_core
  import alu_ctrl_mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             flush,
  input  logic             step,
  input  logic [1:0]       op,      // funct[1:0]: bit1 = divide, bit0 = unsigned
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] hi_res,
  output logic [WIDTH-1:0] lo_res
);
  localparam int CW = $clog2(WIDTH + 1);

  // p holds {acc, multiplier} for MUL and {remainder, quotient} for DIV
  logic [2*WIDTH-1:0] p;
  logic [WIDTH-1:0]   m, a_raw;
  logic [CW-1:0]      cnt;
  logic               is_div, neg_q, neg_r, div0;

  logic               sgn;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, rem_sh, diff;
  logic [2*WIDTH-1:0] mul_nxt, div_nxt, prod_fix;
  logic [WIDTH-1:0]   q_fix, r_fix;

  assign sgn   = ~op[0];
  assign a_mag = (sgn && a[WIDTH-1]) ? -a : a;
  assign b_mag = (sgn && b[WIDTH-1]) ? -b : b;

  assign mul_sum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : '0);
  assign mul_nxt = {mul_sum, p[WIDTH-1:1]};

  assign rem_sh  = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
  assign diff    = rem_sh - {1'b0, m};
  assign div_nxt = diff[WIDTH] ? {rem_sh[WIDTH-1:0], p[WIDTH-2:0], 1'b0}
                               : {diff[WIDTH-1:0],   p[WIDTH-2:0], 1'b1};

  assign last = step && (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p      <= '0;
      m      <= '0;
      a_raw  <= '0;
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
    end else if (start) begin
      p      <= {{WIDTH{1'b0}}, a_mag};
      m      <= b_mag;
      a_raw  <= a;
      cnt    <= '0;
      is_div <= op[1];
      neg_q  <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_r  <= sgn & a[WIDTH-1];
      div0   <= (b == '0);
    end else if (flush) begin
      cnt <= '0;
    end else if (step) begin
      p   <= is_div ? div_nxt : mul_nxt;
      cnt <= last ? '0 : cnt + 1'b1;
    end
  end

  assign prod_fix = neg_q ? -p : p;
  assign q_fix    = neg_q ? -p[WIDTH-1:0] : p[WIDTH-1:0];
  assign r_fix    = neg_r ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];

  // divide by zero bypasses sign fix: quotient all ones, remainder is the raw dividend
  assign hi_res = is_div ? (div0 ? a_raw : r_fix) : prod_fix[2*WIDTH-1:WIDTH];
  assign lo_res = is_div ? (div0 ? '1 : q_fix)    : prod_fix[WIDTH-1:0];

endmodule

// File: rtl/alu_ctrl_mdu.sv
// EX-stage ALU control decoder plus multiply/divide sequencing and the HI/LO register pair.
module alu_ctrl_mdu
  import alu_ctrl_mdu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int FUNC_W = 6,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        aluop,
  input  logic [FUNC_W-1:0] func_code,
  input  logic              start,
  input  logic              flush,
  input  logic [WIDTH-1:0]  src_a,
  input  logic [WIDTH-1:0]  src_b,
  output logic [CTRL_W-1:0] control,
  output logic              illegal,
  output logic              mdu_sel,
  output logic [WIDTH-1:0]  hilo_rd,
  output logic              busy,
  output logic              stall,
  output logic              done,
  output logic [WIDTH-1:0]  hi,
  output logic [WIDTH-1:0]  lo
);
  logic [5:0]       f;
  dec_t             dec;
  mdu_state_e       state;
  logic             core_start, core_step, core_last;
  logic [WIDTH-1:0] hi_res, lo_res;

  assign f       = 6'(func_code);
  assign dec     = decode(aluop, f);
  assign control = CTRL_W'(dec.ctrl);
  assign illegal = dec.illegal;
  assign mdu_sel = dec.mf;
  assign hilo_rd = (f == FUNC_MFHI) ? hi : lo;
  assign stall   = busy | (start & dec.mdu_op & ~busy) | (start & dec.mf & busy);

  assign core_start = (state == ST_IDLE) && start && !flush && dec.mdu_op;
  assign core_step  = (state == ST_RUN) && !flush;

  alu_ctrl_mdu_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (core_start),
    .flush  (flush),
    .step   (core_step),
    .op     (f[1:0]),
    .a      (src_a),
    .b      (src_b),
    .last   (core_last),
    .hi_res (hi_res),
    .lo_res (lo_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && !flush) begin
            if (dec.mdu_op) begin
              state <= ST_RUN;
              busy  <= 1'b1;
            end else if (dec.mt) begin
              if (f == FUNC_MTHI) hi <= src_a;
              else                lo <= src_a;
            end
          end
        end
        ST_RUN: begin
          if (flush) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (core_last) begin
            state <= ST_FIX;
          end
        end
        ST_FIX: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          if (!flush) begin
            hi   <= hi_res;
            lo   <= lo_res;
            done <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
